// File: rtl/mem_stage_sequencer_pkg.sv
// rtl/mem_stage_sequencer_pkg.sv - shared types and constants for the node-memory stage sequencer
//
// Purpose: state encoding, node memory geometry and routing stage indices
// shared by the sequencer top and its next-stage finder.
package mem_stage_sequencer_pkg;

    localparam int MEM_DEPTH   = 2048;
    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 16;
    localparam int STAGE_IDX_W = 3;

    // Routing stage indices, in execution order.
    localparam int LEARN   = 0;
    localparam int SINK    = 1;
    localparam int FIXLIST = 2;
    localparam int NSIOC   = 3;
    localparam int BEST    = 4;
    localparam int BETTER  = 5;
    localparam int WINNER  = 6;
    localparam int ACTION  = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/mem_stage_sequencer_next_stage_finder.sv
// rtl/mem_stage_sequencer_next_stage_finder.sv - combinational search for the next enabled stage
//
// Purpose: given a stage mask and the current index, return the lowest
// enabled index strictly above the current one (or the lowest enabled index
// overall when first=1).
// Ports:
//   mask  in  N_STAGES     : enabled-stage mask
//   cur   in  STAGE_IDX_W  : current stage index
//   first in  1            : search from index 0 inclusive, ignoring cur
//   nxt   out STAGE_IDX_W  : next enabled index (0 when none)
//   none  out 1            : no enabled index found
module next_stage_finder
    import mem_stage_sequencer_pkg::*;
#(
    parameter int N_STAGES = 8
) (
    input  logic [N_STAGES-1:0]    mask,
    input  logic [STAGE_IDX_W-1:0] cur,
    input  logic                   first,
    output logic [STAGE_IDX_W-1:0] nxt,
    output logic                   none
);

    // Walk from the top down so the lowest qualifying index is the last
    // one written and therefore wins.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (mask[i] && (first || (STAGE_IDX_W'(i) > cur))) begin
                nxt  = STAGE_IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_stage_sequencer.sv
// rtl/mem_stage_sequencer.sv - sequences routing stages and arbitrates the shared node memory port
//
// Purpose: runs the enabled routing stages one at a time, giving each a
// one-cycle start pulse and exclusive use of the node memory port until it
// reports done; adds skip mask, watchdog and abort.
// Ports:
//   clock, rst                 : clock and synchronous active-high reset
//   en, abort                  : run request (IDLE only) and run cancel
//   stage_en                   : skip mask, latched at run start
//   stage_done/addr/wren/wdata : per-stage done level and memory requests
//   stage_start                : one-hot start pulses
//   address, wr_en, mem_data_in: granted memory port
//   active_stage, busy         : port owner index and run-in-progress flag
//   run_done, timeout_err      : run completion pulse and sticky watchdog flag
module mem_stage_sequencer #(
    parameter int N_STAGES = 8,
    parameter int ADDR_W   = mem_stage_sequencer_pkg::ADDR_W,
    parameter int DATA_W   = mem_stage_sequencer_pkg::DATA_W,
    parameter int TIMEOUT  = 1023
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       abort,
    input  logic [N_STAGES-1:0]        stage_en,
    input  logic [N_STAGES-1:0]        stage_done,
    input  logic [N_STAGES*ADDR_W-1:0] stage_addr,
    input  logic [N_STAGES-1:0]        stage_wren,
    input  logic [N_STAGES*DATA_W-1:0] stage_wdata,
    output logic [N_STAGES-1:0]        stage_start,
    output logic [ADDR_W-1:0]          address,
    output logic                       wr_en,
    output logic [DATA_W-1:0]          mem_data_in,
    output logic [2:0]                 active_stage,
    output logic                       busy,
    output logic                       run_done,
    output logic                       timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    mem_stage_sequencer_pkg::seq_state_t state_q, state_d;

    logic [2:0]          active_q, active_d;
    logic [N_STAGES-1:0] mask_q, mask_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                busy_q;
    logic                terr_q;

    logic [2:0]          first_idx;
    logic                first_none;
    logic [2:0]          next_idx;
    logic                next_none;

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_wren;
    logic                sel_done;
    logic                timeout_hit;

    // Lowest enabled stage of the incoming mask, used when a run begins.
    next_stage_finder #(.N_STAGES(N_STAGES)) u_first_finder (
        .mask  (stage_en),
        .cur   (3'd0),
        .first (1'b1),
        .nxt   (first_idx),
        .none  (first_none)
    );

    // Successor of the active stage within the latched mask.
    next_stage_finder #(.N_STAGES(N_STAGES)) u_next_finder (
        .mask  (mask_q),
        .cur   (active_q),
        .first (1'b0),
        .nxt   (next_idx),
        .none  (next_none)
    );

    // Select the active stage's request lines; out-of-range indices select nothing.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wren = 1'b0;
        sel_done = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (active_q == 3'(i)) begin
                sel_addr = stage_addr[i*ADDR_W +: ADDR_W];
                sel_data = stage_wdata[i*DATA_W +: DATA_W];
                sel_wren = stage_wren[i];
                sel_done = stage_done[i];
            end
        end
    end

    // Fires on the last of TIMEOUT WAIT cycles; the counter saturates, so it
    // cannot wrap past this value.
    assign timeout_hit = (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        mask_d   = mask_q;
        wd_d     = wd_q;
        case (state_q)
            mem_stage_sequencer_pkg::ST_IDLE: begin
                if (en) begin
                    if (!first_none) begin
                        mask_d   = stage_en;
                        active_d = first_idx;
                        state_d  = mem_stage_sequencer_pkg::ST_START;
                    end else begin
                        state_d  = mem_stage_sequencer_pkg::ST_FINISH;
                    end
                end
            end
            mem_stage_sequencer_pkg::ST_START: begin
                // Done is deliberately not looked at here so a level left
                // over from an earlier run cannot skip the stage.
                wd_d    = '0;
                state_d = mem_stage_sequencer_pkg::ST_WAIT;
            end
            mem_stage_sequencer_pkg::ST_WAIT: begin
                if (wd_q != WD_W'(TIMEOUT)) begin
                    wd_d = wd_q + 1'b1;
                end
                if (sel_done) begin
                    if (!next_none) begin
                        active_d = next_idx;
                        state_d  = mem_stage_sequencer_pkg::ST_START;
                    end else begin
                        state_d  = mem_stage_sequencer_pkg::ST_FINISH;
                    end
                end else if (timeout_hit) begin
                    state_d = mem_stage_sequencer_pkg::ST_ERROR;
                end
            end
            mem_stage_sequencer_pkg::ST_FINISH: begin
                state_d = mem_stage_sequencer_pkg::ST_IDLE;
            end
            mem_stage_sequencer_pkg::ST_ERROR: begin
                state_d = mem_stage_sequencer_pkg::ST_ERROR;
            end
            default: begin
                state_d = mem_stage_sequencer_pkg::ST_IDLE;
            end
        endcase
        if (abort && (state_q != mem_stage_sequencer_pkg::ST_IDLE)) begin
            state_d = mem_stage_sequencer_pkg::ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= mem_stage_sequencer_pkg::ST_IDLE;
            active_q <= '0;
            mask_q   <= '0;
            wd_q     <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            mask_q   <= mask_d;
            wd_q     <= wd_d;
            busy_q   <= (state_d != mem_stage_sequencer_pkg::ST_IDLE);
            if (state_d == mem_stage_sequencer_pkg::ST_ERROR) begin
                terr_q <= 1'b1;
            end
        end
    end

    always_comb begin
        stage_start = '0;
        if (state_q == mem_stage_sequencer_pkg::ST_START) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (active_q == 3'(i)) begin
                    stage_start[i] = 1'b1;
                end
            end
        end
    end

    assign address      = (state_q == mem_stage_sequencer_pkg::ST_IDLE) ? '0 : sel_addr;
    assign mem_data_in  = (state_q == mem_stage_sequencer_pkg::ST_IDLE) ? '0 : sel_data;
    assign wr_en        = sel_wren && (state_q == mem_stage_sequencer_pkg::ST_WAIT) && !abort;
    assign run_done     = (state_q == mem_stage_sequencer_pkg::ST_FINISH) && !abort;
    assign active_stage = active_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// tb/tb_mem_stage_sequencer.sv - directed self-checking bench for mem_stage_sequencer
module tb_mem_stage_sequencer;

    logic         clock;
    logic         rst;
    logic         en;
    logic         abort;
    logic [7:0]   stage_en;
    logic [7:0]   stage_done;
    logic [87:0]  stage_addr;
    logic [7:0]   stage_wren;
    logic [127:0] stage_wdata;
    logic [7:0]   stage_start;
    logic [10:0]  address;
    logic         wr_en;
    logic [15:0]  mem_data_in;
    logic [2:0]   active_stage;
    logic         busy;
    logic         run_done;
    logic         timeout_err;

    logic [7:0]   model_done;
    logic [7:0]   man_done;
    logic         model_on;

    int checks = 0;
    int errors = 0;

    assign stage_done = model_done | man_done;

    mem_stage_sequencer #(
        .N_STAGES (8),
        .ADDR_W   (11),
        .DATA_W   (16),
        .TIMEOUT  (16)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .en           (en),
        .abort        (abort),
        .stage_en     (stage_en),
        .stage_done   (stage_done),
        .stage_addr   (stage_addr),
        .stage_wren   (stage_wren),
        .stage_wdata  (stage_wdata),
        .stage_start  (stage_start),
        .address      (address),
        .wr_en        (wr_en),
        .mem_data_in  (mem_data_in),
        .active_stage (active_stage),
        .busy         (busy),
        .run_done     (run_done),
        .timeout_err  (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench stalled");
    end

    // Stage model: done pulses exactly 3 cycles after the stage's start.
    initial begin
        int cnt [8];
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        model_done = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 8; i++) begin
                model_done[i] = 1'b0;
                if (cnt[i] > 0) begin
                    cnt[i] = cnt[i] - 1;
                    if (cnt[i] == 0 && model_on) model_done[i] = 1'b1;
                end
                if (stage_start[i] && model_on) cnt[i] = 3;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one packet with the stage model active and checks every cycle
    // against a schedule built from the mask: each stage takes 4 cycles.
    task automatic run_expect(input logic [7:0] m);
        int idx [$];
        int n;
        for (int i = 0; i < 8; i++) if (m[i]) idx.push_back(i);
        n = idx.size();
        stage_en = m;
        en = 1'b1;
        step();
        en = 1'b0;
        for (int k = 1; k <= 4*n + 3; k++) begin
            int j;
            logic [7:0]  es;
            logic [10:0] ea;
            logic [15:0] ed;
            logic        ew;
            j = (k - 1) / 4;
            if (j > n - 1) j = n - 1;
            es = (((k - 1) % 4 == 0) && (k <= 4*n)) ? 8'(1 << idx[j]) : 8'h00;
            ea = (k <= 4*n + 1) ? stage_addr[idx[j]*11 +: 11] : 11'h000;
            ed = (k <= 4*n + 1) ? stage_wdata[idx[j]*16 +: 16] : 16'h0000;
            ew = (k <= 4*n) && ((k - 1) % 4 != 0) && stage_wren[idx[j]];
            check("stage_start", 32'(stage_start), 32'(es));
            check("run_done", 32'(run_done), 32'(k == 4*n + 1));
            check("busy", 32'(busy), 32'(k <= 4*n + 1));
            check("address", 32'(address), 32'(ea));
            check("mem_data_in", 32'(mem_data_in), 32'(ed));
            check("wr_en", 32'(wr_en), 32'(ew));
            if (k <= 4*n + 1) check("active_stage", 32'(active_stage), 32'(idx[j]));
            step();
        end
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        abort       = 1'b0;
        stage_en    = 8'h00;
        man_done    = 8'h00;
        model_on    = 1'b0;
        stage_wren  = 8'h00;
        stage_addr  = {11'h787, 11'h076, 11'h065, 11'h148, 11'h043, 11'h032, 11'h021, 11'h010};
        stage_wdata = {16'hA777, 16'hA666, 16'hA555, 16'hA444, 16'hA333, 16'hA222, 16'hA111, 16'hA000};
        step();
        step();

        // Reset values.
        check("rst_stage_start", 32'(stage_start), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_run_done", 32'(run_done), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        check("rst_active_stage", 32'(active_stage), 32'h0);
        check("rst_address", 32'(address), 32'h0);
        check("rst_mem_data_in", 32'(mem_data_in), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        rst = 1'b0;
        step();

        // Full run, every stage writing.
        model_on   = 1'b1;
        stage_wren = 8'hFF;
        run_expect(8'hFF);
        step();

        // Skip mask; stage 4 wants to write 0x148 but is never granted.
        stage_wren = 8'h10;
        run_expect(8'hA5);
        step();

        // Empty mask goes straight to FINISH.
        stage_en = 8'h00;
        en = 1'b1;
        step();
        en = 1'b0;
        check("empty_run_done", 32'(run_done), 32'h1);
        check("empty_busy", 32'(busy), 32'h1);
        check("empty_stage_start", 32'(stage_start), 32'h0);
        step();
        check("empty_idle_busy", 32'(busy), 32'h0);
        check("empty_idle_run_done", 32'(run_done), 32'h0);

        // Stale done level on stage 1.
        model_on = 1'b0;
        step();
        step();
        man_done = 8'h02;
        stage_en = 8'h02;
        step();
        check("stale_idle_busy", 32'(busy), 32'h0);
        en = 1'b1;
        step();
        en = 1'b0;
        check("stale_start", 32'(stage_start), 32'h02);
        check("stale_active", 32'(active_stage), 32'h1);
        step();
        check("stale_wait_start", 32'(stage_start), 32'h0);
        check("stale_wait_busy", 32'(busy), 32'h1);
        check("stale_wait_run_done", 32'(run_done), 32'h0);
        step();
        check("stale_finish_run_done", 32'(run_done), 32'h1);
        check("stale_finish_start", 32'(stage_start), 32'h0);
        step();
        check("stale_idle_after", 32'(busy), 32'h0);
        man_done = 8'h00;

        // Watchdog on stage 3.
        stage_en   = 8'h08;
        stage_wren = 8'h08;
        en = 1'b1;
        step();
        en = 1'b0;
        check("wd_start", 32'(stage_start), 32'h08);
        for (int k = 2; k <= 17; k++) begin
            step();
            check("wd_wait_wr_en", 32'(wr_en), 32'h1);
            check("wd_wait_terr", 32'(timeout_err), 32'h0);
        end
        step();
        check("wd_err_terr", 32'(timeout_err), 32'h1);
        check("wd_err_wr_en", 32'(wr_en), 32'h0);
        check("wd_err_busy", 32'(busy), 32'h1);
        check("wd_err_run_done", 32'(run_done), 32'h0);
        step();
        step();
        check("wd_err_hold_busy", 32'(busy), 32'h1);
        check("wd_err_hold_terr", 32'(timeout_err), 32'h1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("wd_abort_busy", 32'(busy), 32'h0);
        check("wd_abort_terr", 32'(timeout_err), 32'h1);
        step();
        check("wd_sticky_terr", 32'(timeout_err), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wd_rst_terr", 32'(timeout_err), 32'h0);
        step();

        // Mid-run abort during stage 5 WAIT.
        model_on   = 1'b1;
        stage_en   = 8'hFF;
        stage_wren = 8'hFF;
        en = 1'b1;
        step();
        en = 1'b0;
        for (int k = 2; k <= 22; k++) step();
        check("abort_pre_active", 32'(active_stage), 32'h5);
        check("abort_pre_wr_en", 32'(wr_en), 32'h1);
        abort = 1'b1;
        #1;
        check("abort_wr_en", 32'(wr_en), 32'h0);
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_address", 32'(address), 32'h0);
        check("abort_stage_start", 32'(stage_start), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check("abort_no_run_done", 32'(run_done), 32'h0);
            step();
        end

        // Reset in stage 2 WAIT, then a fresh run.
        en = 1'b1;
        step();
        en = 1'b0;
        for (int k = 2; k <= 10; k++) step();
        check("rstmid_pre_active", 32'(active_stage), 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_stage_start", 32'(stage_start), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_run_done", 32'(run_done), 32'h0);
        check("rstmid_terr", 32'(timeout_err), 32'h0);
        check("rstmid_active", 32'(active_stage), 32'h0);
        check("rstmid_address", 32'(address), 32'h0);
        check("rstmid_mem_data_in", 32'(mem_data_in), 32'h0);
        check("rstmid_wr_en", 32'(wr_en), 32'h0);
        step();
        step();
        step();
        run_expect(8'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
